dclcg_gen: RTL and testbench

DCLCG_GEN -- requirements
Module: dclcg_gen

---
 rtl/dclcg_gen.sv | 184 ++++++++++++++++++
 tb/tb_dclcg_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dclcg_gen.sv
// Dual-comparison LCG bit generator: four LCGs X/Y/P/Q with multipliers 2^r+1,
// decimated bit stream (bit = X>Y, kept when P>Q) packed LSB-first into words.
module dclcg_gen #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int WORD  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [WIDTH-1:0] x_seed,
  input  logic [WIDTH-1:0] y_seed,
  input  logic [WIDTH-1:0] p_seed,
  input  logic [WIDTH-1:0] q_seed,
  input  logic [SHW-1:0]   r1,
  input  logic [SHW-1:0]   r2,
  input  logic [SHW-1:0]   r3,
  input  logic [SHW-1:0]   r4,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] c2,
  input  logic [WIDTH-1:0] c3,
  input  logic [WIDTH-1:0] c4,
  output logic             running,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [WORD-1:0]  word_out,
  output logic             word_valid
);

  localparam int            CW   = (WORD > 1) ? $clog2(WORD) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_x, r_y, r_p, r_q;
  logic [SHW-1:0]   r_r1, r_r2, r_r3, r_r4;
  logic [WIDTH-1:0] r_c1, r_c2, r_c3, r_c4;
  logic [CW-1:0]    r_cnt;
  logic [WORD-1:0]  r_part;
  logic             r_bit_out;
  logic             r_bit_valid;
  logic [WORD-1:0]  r_word_out;
  logic             r_word_valid;

  logic             w_step;
  logic             w_b1;
  logic             w_b2;
  logic             w_last;
  logic [WIDTH-1:0] w_x_nxt, w_y_nxt, w_p_nxt, w_q_nxt;
  logic [WORD-1:0]  w_part_nxt;

  // The shift is evaluated at WIDTH bits, so any r >= WIDTH shifts everything out.
  function automatic logic [WIDTH-1:0] lcg_next(
    input logic [WIDTH-1:0] s,
    input logic [SHW-1:0]   sh,
    input logic [WIDTH-1:0] c
  );
    return s + (s << sh) + c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_RUN;
    end else if (stop) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign w_step  = (r_state == S_RUN) && en && !start;
  assign w_b1    = (r_x > r_y);
  assign w_b2    = (r_p > r_q);
  assign w_last  = (r_cnt == LAST);

  assign w_x_nxt = lcg_next(r_x, r_r1, r_c1);
  assign w_y_nxt = lcg_next(r_y, r_r2, r_c2);
  assign w_p_nxt = lcg_next(r_p, r_r3, r_c3);
  assign w_q_nxt = lcg_next(r_q, r_r4, r_c4);

  always_comb begin
    w_part_nxt        = r_part;
    w_part_nxt[r_cnt] = w_b1;
  end

  // Configuration registers: r and c are only ever used from these copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
      r_r4 <= '0;
      r_c1 <= '0;
      r_c2 <= '0;
      r_c3 <= '0;
      r_c4 <= '0;
    end else if (start) begin
      r_r1 <= r1;
      r_r2 <= r2;
      r_r3 <= r3;
      r_r4 <= r4;
      r_c1 <= c1;
      r_c2 <= c2;
      r_c3 <= c3;
      r_c4 <= c4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
      r_p <= '0;
      r_q <= '0;
    end else if (start) begin
      r_x <= x_seed;
      r_y <= y_seed;
      r_p <= p_seed;
      r_q <= q_seed;
    end else if (w_step) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      r_p <= w_p_nxt;
      r_q <= w_q_nxt;
    end
  end

  // Decimation and packing: only steps with P>Q produce a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_part       <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
    end else if (start) begin
      r_cnt        <= '0;
      r_part       <= '0;
      r_bit_valid  <= 1'b0;
      r_word_valid <= 1'b0;
    end else if (w_step) begin
      r_bit_valid  <= w_b2;
      r_word_valid <= 1'b0;
      if (w_b2) begin
        r_bit_out <= w_b1;
        if (w_last) begin
          r_word_out   <= w_part_nxt;
          r_word_valid <= 1'b1;
          r_cnt        <= '0;
          r_part       <= '0;
        end else begin
          r_part <= w_part_nxt;
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end else begin
      r_bit_valid  <= 1'b0;
      r_word_valid <= 1'b0;
    end
  end

  assign running    = (r_state == S_RUN);
  assign bit_out    = r_bit_out;
  assign bit_valid  = r_bit_valid;
  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;

endmodule

// File: tb/tb_dclcg_gen.sv
// Bench for dclcg_gen: directed vector table, behavioural reference model runs,
// and hand sequences for restart, stop/hold, narrow-width shifts and reset.
module tb_dclcg_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, stop, en;
  logic [7:0] xs, ys, ps, qs, c1, c2, c3, c4;
  logic [2:0] r1, r2, r3, r4;
  logic       running, bit_out, bit_valid, word_valid;
  logic [7:0] word_out;

  logic [3:0] xs4, ys4, ps4, qs4, c14, c24, c34, c44;
  logic [2:0] r14, r24, r34, r44;
  logic       run4, bo4, bv4, wv4;
  logic [7:0] wo4;

  dclcg_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en),
    .x_seed(xs), .y_seed(ys), .p_seed(ps), .q_seed(qs),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .running(running), .bit_out(bit_out), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid)
  );

  dclcg_gen #(.WIDTH(4), .SHW(3), .WORD(8)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en),
    .x_seed(xs4), .y_seed(ys4), .p_seed(ps4), .q_seed(qs4),
    .r1(r14), .r2(r24), .r3(r34), .r4(r44),
    .c1(c14), .c2(c24), .c3(c34), .c4(c44),
    .running(run4), .bit_out(bo4), .bit_valid(bv4),
    .word_out(wo4), .word_valid(wv4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic e);
    start = s;
    stop  = p;
    en    = e;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       st;
    logic       en;
    logic       bv;
    logic       bo;
    logic [7:0] x, y, p, q;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic e, input logic v, input logic o,
                              input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] p, input logic [7:0] q);
    vec_t t;
    t.st = s; t.en = e; t.bv = v; t.bo = o;
    t.x = x; t.y = y; t.p = p; t.q = q;
    return t;
  endfunction

  // Reference model: multiplier form rather than shift form.
  logic [7:0] mx, my, mp, mq, mc1, mc2, mc3, mc4, mpart, mwo;
  logic [2:0] mr1, mr2, mr3, mr4;
  logic       mbo, mbv, mwv, mrun;
  int         mcnt;

  function automatic logic [7:0] mlcg(input logic [7:0] s, input logic [2:0] r, input logic [7:0] c);
    int a;
    a = (1 << r) + 1;
    return 8'((int'(s) * a + int'(c)) % 256);
  endfunction

  task automatic mapply(input logic s, input logic p, input logic e);
    logic b1, b2;
    if (s) begin
      mx = xs; my = ys; mp = ps; mq = qs;
      mr1 = r1; mr2 = r2; mr3 = r3; mr4 = r4;
      mc1 = c1; mc2 = c2; mc3 = c3; mc4 = c4;
      mcnt = 0; mpart = 8'd0; mbv = 1'b0; mwv = 1'b0;
    end else if (mrun && e) begin
      b1 = (mx > my);
      b2 = (mp > mq);
      mx = mlcg(mx, mr1, mc1); my = mlcg(my, mr2, mc2);
      mp = mlcg(mp, mr3, mc3); mq = mlcg(mq, mr4, mc4);
      mbv = b2;
      mwv = 1'b0;
      if (b2) begin
        mbo = b1;
        mpart[mcnt] = b1;
        mcnt++;
        if (mcnt == 8) begin
          mwo = mpart; mwv = 1'b1; mcnt = 0; mpart = 8'd0;
        end
      end
    end else begin
      mbv = 1'b0;
      mwv = 1'b0;
    end
    if (s) mrun = 1'b1;
    else if (p) mrun = 1'b0;
    step(s, p, e);
  endtask

  task automatic cmp(input string tag);
    chk({tag, ".bit_valid"}, 32'(bit_valid), 32'(mbv));
    chk({tag, ".bit_out"}, 32'(bit_out), 32'(mbo));
    chk({tag, ".word_valid"}, 32'(word_valid), 32'(mwv));
    chk({tag, ".word_out"}, 32'(word_out), 32'(mwo));
    chk({tag, ".running"}, 32'(running), 32'(mrun));
  endtask

  vec_t       tbl[9];
  logic       q_cont[$];
  logic [7:0] fw;
  int         nv, nw, k, cnt;
  logic       e;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0;
    xs = 8'd25; ys = 8'd15; ps = 8'd10; qs = 8'd13;
    r1 = 3'd4; r2 = 3'd2; r3 = 3'd4; r4 = 3'd3;
    c1 = 8'd47; c2 = 8'd23; c3 = 8'd47; c4 = 8'd23;
    xs4 = 4'd5; ys4 = 4'd3; ps4 = 4'd9; qs4 = 4'd2;
    r14 = 3'd7; r24 = 3'd1; r34 = 3'd0; r44 = 3'd4;
    c14 = 4'd3; c24 = 4'd2; c34 = 4'd1; c44 = 4'd0;
    #1 rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("rst.running", 32'(running), 32'd0);
    chk("rst.bit_out", 32'(bit_out), 32'd0);
    chk("rst.bit_valid", 32'(bit_valid), 32'd0);
    chk("rst.word_out", 32'(word_out), 32'd0);
    chk("rst.word_valid", 32'(word_valid), 32'd0);
    chk("rst.x", 32'(dut.r_x), 32'd0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    chk("post_rst.idle", 32'(running), 32'd0);

    tbl[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd25,  8'd15,  8'd10,  8'd13);
    tbl[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd216, 8'd98,  8'd217, 8'd140);
    tbl[2] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'd135, 8'd1,   8'd152, 8'd3);
    tbl[3] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'd38,  8'd28,  8'd71,  8'd50);
    tbl[4] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd38,  8'd28,  8'd71,  8'd50);
    tbl[5] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'd181, 8'd163, 8'd230, 8'd217);
    tbl[6] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'd52,  8'd70,  8'd117, 8'd184);
    tbl[7] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd163, 8'd117, 8'd244, 8'd143);
    tbl[8] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'd2,   8'd96,  8'd99,  8'd30);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].st, 1'b0, tbl[i].en);
      chk($sformatf("tbl%0d.bit_valid", i), 32'(bit_valid), 32'(tbl[i].bv));
      chk($sformatf("tbl%0d.bit_out", i), 32'(bit_out), 32'(tbl[i].bo));
      chk($sformatf("tbl%0d.word_valid", i), 32'(word_valid), 32'd0);
      chk($sformatf("tbl%0d.running", i), 32'(running), 32'd1);
      chk($sformatf("tbl%0d.x", i), 32'(dut.r_x), 32'(tbl[i].x));
      chk($sformatf("tbl%0d.y", i), 32'(dut.r_y), 32'(tbl[i].y));
      chk($sformatf("tbl%0d.p", i), 32'(dut.r_p), 32'(tbl[i].p));
      chk($sformatf("tbl%0d.q", i), 32'(dut.r_q), 32'(tbl[i].q));
    end

    // Narrow instance: r=7 and r=4 shift out completely at WIDTH=4, r=0 doubles.
    step(1'b1, 1'b0, 1'b0);
    chk("w4.load_x", 32'(u4.r_x), 32'd5);
    step(1'b0, 1'b0, 1'b1);
    chk("w4.s1_x", 32'(u4.r_x), 32'd8);
    chk("w4.s1_y", 32'(u4.r_y), 32'd11);
    chk("w4.s1_p", 32'(u4.r_p), 32'd3);
    chk("w4.s1_q", 32'(u4.r_q), 32'd2);
    step(1'b0, 1'b0, 1'b1);
    chk("w4.s2_x", 32'(u4.r_x), 32'd11);
    chk("w4.s2_y", 32'(u4.r_y), 32'd3);
    chk("w4.s2_p", 32'(u4.r_p), 32'd7);
    step(1'b0, 1'b1, 1'b0);
    chk("w4.stop_running", 32'(run4), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("w4.idle_x", 32'(u4.r_x), 32'd11);
    chk("w4.idle_y", 32'(u4.r_y), 32'd3);
    chk("w4.idle_p", 32'(u4.r_p), 32'd7);
    chk("w4.idle_q", 32'(u4.r_q), 32'd2);
    chk("w4.idle_bv", 32'(bv4), 32'd0);

    // Random configuration, continuous enable, against the model.
    xs = 8'($urandom); ys = 8'($urandom); ps = 8'($urandom); qs = 8'($urandom);
    r1 = 3'($urandom_range(7, 2)); r2 = 3'($urandom_range(7, 2));
    r3 = 3'($urandom_range(7, 2)); r4 = 3'($urandom_range(7, 2));
    c1 = 8'($urandom) | 8'd1; c2 = 8'($urandom) | 8'd1;
    c3 = 8'($urandom) | 8'd1; c4 = 8'($urandom) | 8'd1;
    mbo = bit_out; mwo = word_out; mrun = running;
    mapply(1'b1, 1'b0, 1'b1);
    cmp("load");
    nv = 0; nw = 0;
    for (int i = 0; i < 1000; i++) begin
      mapply(1'b0, 1'b0, 1'b1);
      cmp("cont");
      if (mbv) q_cont.push_back(mbo);
      if (bit_valid) nv++;
      if (word_valid) nw++;
    end
    chk("cont.word_count", 32'(nw), 32'(nv / 8));

    // Same configuration with enable toggling every cycle.
    mapply(1'b1, 1'b0, 1'b1);
    k = 0;
    for (int i = 0; i < 2000; i++) begin
      e = (i % 2 == 1);
      mapply(1'b0, 1'b0, e);
      cmp("tog");
      if (!e) chk("tog.no_valid_when_idle_en", 32'(bit_valid), 32'd0);
      if (bit_valid) begin
        if (k < q_cont.size()) chk("tog.seq", 32'(bit_out), 32'(q_cont[k]));
        k++;
      end
    end
    chk("tog.len", 32'(k), 32'(q_cont.size()));

    // Restart mid-word with the same seeds.
    chk("cont.enough_bits", 32'(q_cont.size() >= 8), 32'd1);
    fw = 8'd0;
    for (int j = 0; j < 8 && j < q_cont.size(); j++) fw[j] = q_cont[j];
    mapply(1'b1, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 300 && cnt < 3; i++) begin
      mapply(1'b0, 1'b0, 1'b1);
      cmp("pre");
      if (bit_valid) cnt++;
    end
    chk("restart.three_bits", 32'(cnt), 32'd3);
    mapply(1'b1, 1'b0, 1'b1);
    cmp("restart_load");
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      mapply(1'b0, 1'b0, 1'b1);
      cmp("restart");
      if (bit_valid) cnt++;
      if (word_valid) break;
    end
    chk("restart.bits_to_word", 32'(cnt), 32'd8);
    chk("restart.word", 32'(word_out), 32'(fw));

    // Stop holds everything; steps in IDLE do nothing.
    for (int i = 0; i < 5; i++) begin
      mapply(1'b0, 1'b0, 1'b1);
      cmp("prestop");
    end
    mapply(1'b0, 1'b1, 1'b0);
    cmp("stop");
    for (int i = 0; i < 4; i++) begin
      mapply(1'b0, 1'b0, 1'b1);
      cmp("idle");
      chk("idle.x", 32'(dut.r_x), 32'(mx));
      chk("idle.y", 32'(dut.r_y), 32'(my));
      chk("idle.p", 32'(dut.r_p), 32'(mp));
      chk("idle.q", 32'(dut.r_q), 32'(mq));
      chk("idle.cnt", 32'(dut.r_cnt), 32'(mcnt));
    end

    // Asynchronous reset mid-run, overriding start.
    mapply(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) mapply(1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.running", 32'(running), 32'd0);
    chk("arst.bit_out", 32'(bit_out), 32'd0);
    chk("arst.bit_valid", 32'(bit_valid), 32'd0);
    chk("arst.word_out", 32'(word_out), 32'd0);
    chk("arst.word_valid", 32'(word_valid), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("arst.start_ignored", 32'(running), 32'd0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("arst.stays_idle", 32'(running), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("start_and_stop.running", 32'(running), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
